// File: rtl/alu_shift_if.sv
// Request/response handshake bundle between the issue stage and the shift sequencer.
// The issuer drives the request fields and resp_ready; the sequencer drives the rest.
interface alu_shift_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_dir;
    logic [DATA_WIDTH-1:0] req_data;
    logic [SHAMT_W-1:0]    req_shamt;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_dir, req_data, req_shamt, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_dir, req_data, req_shamt, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Variable-amount logical shifter built from repeated single-bit SLL/SRL passes
// through the shared ALU; owns the ALU opcode/operands while a shift is in flight.
module alu_shift_sequencer #(
    parameter int             DATA_WIDTH = 32,
    parameter int             SHAMT_W    = 5,
    parameter logic [4:0]     ALU_ADD    = 5'd0,
    parameter logic [4:0]     ALU_SLL    = 5'd7,
    parameter logic [4:0]     ALU_SRL    = 5'd8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  kill,
    alu_shift_if.slave            bus,
    output logic                  busy,
    output logic [4:0]            alu_code,
    output logic [DATA_WIDTH-1:0] alu_operand_a,
    output logic [DATA_WIDTH-1:0] alu_operand_b,
    input  logic [DATA_WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [SHAMT_W-1:0]    r_cnt;
    logic                  r_dir;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_acc_nxt;
    logic [SHAMT_W-1:0]    w_cnt_nxt;
    logic                  w_dir_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_cnt_nxt      = r_cnt;
        w_dir_nxt      = r_dir;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        alu_code       = ALU_ADD;
        alu_operand_a  = '0;

        case (r_state)
            S_IDLE: begin
                bus.req_ready = ~kill;
                if (bus.req_valid && !kill) begin
                    w_acc_nxt   = bus.req_data;
                    w_cnt_nxt   = bus.req_shamt;
                    w_dir_nxt   = bus.req_dir;
                    w_state_nxt = (bus.req_shamt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                alu_code      = r_dir ? ALU_SRL : ALU_SLL;
                alu_operand_a = r_acc;
                if (!kill) begin
                    w_acc_nxt = alu_result;
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == 1) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Dropping valid under kill keeps a killed result from ever handshaking.
                bus.resp_valid = ~kill;
                if (bus.resp_ready && !kill) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort wins over acceptance and handshake; acc/cnt are left as they were.
        if (kill) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = r_acc;
            w_cnt_nxt   = r_cnt;
            w_dir_nxt   = r_dir;
        end
    end

    assign bus.resp_data = r_acc;
    assign busy          = (r_state != S_IDLE);
    assign alu_operand_b = '0;

endmodule
